// File: rtl/register_file.sv
// 8086-style register file: eight 16-bit GPRs, two registered read ports, one write port,
// byte-register addressing and write-first bypass. Optional macro: REGFILE_SP_INIT_EN.
module register_file #(
   parameter logic [15:0] SP_RESET_VALUE = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        is_8_bit,
   input  logic [2:0]  rd_sel [2],
   output logic [15:0] rd_val [2],
   input  logic [2:0]  wr_sel,
   input  logic [15:0] wr_val,
   input  logic        wr_en,
   output logic [15:0] si,
   output logic [15:0] di,
   output logic [15:0] bp,
   output logic [15:0] bx
);

`ifdef REGFILE_SP_INIT_EN
   localparam logic [15:0] SpInit = SP_RESET_VALUE;
`else
   // SP clears like every other register; the parameter is deliberately masked off.
   localparam logic [15:0] SpInit = SP_RESET_VALUE & 16'h0000;
`endif

   localparam int unsigned SpIdx = 4;

   logic [15:0] regs_q   [8];
   logic [15:0] regs_d   [8];
   logic [15:0] rd_val_q [2];
   logic [15:0] rd_val_d [2];
   logic [2:0]  rd_idx   [2];
   logic [15:0] rd_word  [2];
   logic [2:0]  wr_idx;

   // Byte mode only reaches AX..BX; sel[2] then picks the high byte.
   assign wr_idx = is_8_bit ? {1'b0, wr_sel[1:0]} : wr_sel;

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         if (!is_8_bit) begin
            regs_d[wr_idx] = wr_val;
         end else if (wr_sel[2]) begin
            regs_d[wr_idx][15:8] = wr_val[7:0];
         end else begin
            regs_d[wr_idx][7:0] = wr_val[7:0];
         end
      end
   end

   // Reads sample the post-write array, which gives write-first bypass for free.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         rd_idx[i]  = is_8_bit ? {1'b0, rd_sel[i][1:0]} : rd_sel[i];
         rd_word[i] = regs_d[rd_idx[i]];
         if (!is_8_bit) begin
            rd_val_d[i] = rd_word[i];
         end else if (rd_sel[i][2]) begin
            rd_val_d[i] = {8'h00, rd_word[i][15:8]};
         end else begin
            rd_val_d[i] = {8'h00, rd_word[i][7:0]};
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= (i == SpIdx) ? SpInit : 16'h0000;
         end
         rd_val_q[0] <= 16'h0000;
         rd_val_q[1] <= 16'h0000;
      end else begin
         regs_q   <= regs_d;
         rd_val_q <= rd_val_d;
      end
   end

   assign rd_val[0] = rd_val_q[0];
   assign rd_val[1] = rd_val_q[1];

   assign bx = regs_q[3];
   assign bp = regs_q[5];
   assign si = regs_q[6];
   assign di = regs_q[7];

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file; expectations are hand-computed.
module tb_register_file;

   localparam logic [15:0] SpVal = 16'hFFFE;
`ifdef REGFILE_SP_INIT_EN
   localparam logic [15:0] SpExp = SpVal;
`else
   localparam logic [15:0] SpExp = 16'h0000;
`endif

   logic        clk;
   logic        reset;
   logic        is_8_bit;
   logic [2:0]  rd_sel [2];
   logic [15:0] rd_val [2];
   logic [2:0]  wr_sel;
   logic [15:0] wr_val;
   logic        wr_en;
   logic [15:0] si, di, bp, bx;

   register_file #(.SP_RESET_VALUE(SpVal)) dut (
      .clk      (clk),
      .reset    (reset),
      .is_8_bit (is_8_bit),
      .rd_sel   (rd_sel),
      .rd_val   (rd_val),
      .wr_sel   (wr_sel),
      .wr_val   (wr_val),
      .wr_en    (wr_en),
      .si       (si),
      .di       (di),
      .bp       (bp),
      .bx       (bx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        is8;
      logic        we;
      logic [2:0]  ws;
      logic [15:0] wv;
      logic [2:0]  rs0;
      logic [2:0]  rs1;
      logic [15:0] e0;
      logic [15:0] e1;
      logic [15:0] esi;
      logic [15:0] edi;
      logic [15:0] ebp;
      logic [15:0] ebx;
   } vec_t;

   localparam int NumVec = 19;
   vec_t vecs [NumVec];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " rd_val0"}, rd_val[0], 16'h0000);
      check({tag, " rd_val1"}, rd_val[1], 16'h0000);
      check({tag, " si"}, si, 16'h0000);
      check({tag, " di"}, di, 16'h0000);
      check({tag, " bp"}, bp, 16'h0000);
      check({tag, " bx"}, bx, 16'h0000);
   endtask

   initial begin
      //          is8   we    ws    wv        rs0   rs1   e0        e1        si        di        bp        bx
      vecs[0]  = '{1'b0, 1'b1, 3'd0, 16'h1234, 3'd0, 3'd1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      vecs[1]  = '{1'b0, 1'b1, 3'd1, 16'h5678, 3'd0, 3'd1, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      vecs[2]  = '{1'b0, 1'b1, 3'd2, 16'h9ABC, 3'd2, 3'd0, 16'h9ABC, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      vecs[3]  = '{1'b0, 1'b1, 3'd3, 16'hDEF0, 3'd3, 3'd2, 16'hDEF0, 16'h9ABC, 16'h0000, 16'h0000, 16'h0000, 16'hDEF0};
      vecs[4]  = '{1'b0, 1'b1, 3'd0, 16'h1200, 3'd0, 3'd3, 16'h1200, 16'hDEF0, 16'h0000, 16'h0000, 16'h0000, 16'hDEF0};
      vecs[5]  = '{1'b1, 1'b1, 3'd0, 16'h00AA, 3'd0, 3'd4, 16'h00AA, 16'h0012, 16'h0000, 16'h0000, 16'h0000, 16'hDEF0};
      vecs[6]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd1, 16'h12AA, 16'h5678, 16'h0000, 16'h0000, 16'h0000, 16'hDEF0};
      vecs[7]  = '{1'b1, 1'b1, 3'd4, 16'h00BB, 3'd4, 3'd3, 16'h00BB, 16'h00F0, 16'h0000, 16'h0000, 16'h0000, 16'hDEF0};
      vecs[8]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd1, 16'hBBAA, 16'h5678, 16'h0000, 16'h0000, 16'h0000, 16'hDEF0};
      vecs[9]  = '{1'b0, 1'b1, 3'd2, 16'hFFFF, 3'd2, 3'd2, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hDEF0};
      vecs[10] = '{1'b0, 1'b1, 3'd6, 16'hA5A5, 3'd6, 3'd4, 16'hA5A5, SpExp,    16'hA5A5, 16'h0000, 16'h0000, 16'hDEF0};
      vecs[11] = '{1'b0, 1'b1, 3'd7, 16'h5A5A, 3'd7, 3'd6, 16'h5A5A, 16'hA5A5, 16'hA5A5, 16'h5A5A, 16'h0000, 16'hDEF0};
      vecs[12] = '{1'b0, 1'b1, 3'd5, 16'h3C3C, 3'd5, 3'd7, 16'h3C3C, 16'h5A5A, 16'hA5A5, 16'h5A5A, 16'h3C3C, 16'hDEF0};
      vecs[13] = '{1'b0, 1'b1, 3'd3, 16'h0000, 3'd3, 3'd0, 16'h0000, 16'hBBAA, 16'hA5A5, 16'h5A5A, 16'h3C3C, 16'h0000};
      vecs[14] = '{1'b1, 1'b1, 3'd3, 16'h12CC, 3'd3, 3'd7, 16'h00CC, 16'h0000, 16'hA5A5, 16'h5A5A, 16'h3C3C, 16'h00CC};
      vecs[15] = '{1'b1, 1'b1, 3'd7, 16'h00DD, 3'd7, 3'd2, 16'h00DD, 16'h00FF, 16'hA5A5, 16'h5A5A, 16'h3C3C, 16'hDDCC};
      vecs[16] = '{1'b0, 1'b0, 3'd3, 16'h1111, 3'd3, 3'd5, 16'hDDCC, 16'h3C3C, 16'hA5A5, 16'h5A5A, 16'h3C3C, 16'hDDCC};
      vecs[17] = '{1'b1, 1'b1, 3'd1, 16'h0099, 3'd1, 3'd5, 16'h0099, 16'h0056, 16'hA5A5, 16'h5A5A, 16'h3C3C, 16'hDDCC};
      vecs[18] = '{1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd4, 16'h5699, SpExp,    16'hA5A5, 16'h5A5A, 16'h3C3C, 16'hDDCC};

      reset     = 1'b0;
      is_8_bit  = 1'b0;
      rd_sel[0] = 3'd0;
      rd_sel[1] = 3'd0;
      wr_sel    = 3'd0;
      wr_val    = 16'h0000;
      wr_en     = 1'b0;

      // Reset state, checked while reset is still held low across a clock edge.
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < NumVec; i++) begin
         @(negedge clk);
         is_8_bit  = vecs[i].is8;
         wr_en     = vecs[i].we;
         wr_sel    = vecs[i].ws;
         wr_val    = vecs[i].wv;
         rd_sel[0] = vecs[i].rs0;
         rd_sel[1] = vecs[i].rs1;
         @(posedge clk);
         #1;
         check($sformatf("v%0d rd_val0", i), rd_val[0], vecs[i].e0);
         check($sformatf("v%0d rd_val1", i), rd_val[1], vecs[i].e1);
         check($sformatf("v%0d si", i), si, vecs[i].esi);
         check($sformatf("v%0d di", i), di, vecs[i].edi);
         check($sformatf("v%0d bp", i), bp, vecs[i].ebp);
         check($sformatf("v%0d bx", i), bx, vecs[i].ebx);
      end

      // Hold read selects with no write: registered outputs must not drift.
      @(negedge clk);
      wr_en     = 1'b0;
      is_8_bit  = 1'b0;
      rd_sel[0] = 3'd3;
      rd_sel[1] = 3'd6;
      repeat (3) @(posedge clk);
      #1;
      check("hold rd_val0", rd_val[0], 16'hDDCC);
      check("hold rd_val1", rd_val[1], 16'hA5A5);

      // Asynchronous reset in the middle of the low phase, no clock edge in between.
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_all_zero("async reset");

      @(negedge clk);
      reset     = 1'b1;
      rd_sel[0] = 3'd4;
      rd_sel[1] = 3'd0;
      @(posedge clk);
      #1;
      check("post-reset sp", rd_val[0], SpExp);
      check("post-reset ax", rd_val[1], 16'h0000);

      // Byte read of SP's encoding in 8-bit mode selects AH, not SP.
      @(negedge clk);
      is_8_bit = 1'b1;
      wr_en    = 1'b1;
      wr_sel   = 3'd0;
      wr_val   = 16'hFF77;
      @(posedge clk);
      #1;
      check("post-reset ah", rd_val[0], 16'h0000);
      check("post-reset al", rd_val[1], 16'h0077);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
